// File: rtl/output_interface_pkg.sv
// Shared constants for the router output interface: direction encodings,
// default flit width and the requester index map used by the arbiter.
package output_interface_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int NUM_PORTS      = 4;

  typedef enum logic [4:0] {
    DIR_PE = 5'b00001,
    DIR_D  = 5'b00010,
    DIR_U  = 5'b00100,
    DIR_R  = 5'b01000,
    DIR_L  = 5'b10000
  } dir_e;

  // Bit position of each requester inside the arbiter request/grant vectors.
  localparam int PORT_1 = 0;
  localparam int PORT_2 = 1;
  localparam int PORT_3 = 2;
  localparam int PORT_4 = 3;

  function automatic logic [1:0] nextIdx(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/output_interface_arbiter.sv
// Four-way round-robin arbiter; the pointer names the highest-priority
// requester and moves just past whoever was last granted.
module rr_arbiter_4
  import output_interface_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 en_i,
  output logic [NUM_PORTS-1:0] grant_o
);

  logic [1:0] ptr_q;
  logic [1:0] ptr_d;
  logic [1:0] idx;
  logic       found;

  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    idx     = '0;
    found   = 1'b0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      idx = ptr_q + 2'(off);
      if (en_i && !found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        ptr_d        = nextIdx(idx);
        found        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= 2'(PORT_1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/output_interface.sv
// Router output port: a single-entry flit register fed by a round-robin
// choice among the four other input interfaces, drained by so/ro handshake.
module output_interface
  import output_interface_pkg::*;
#(
  parameter int         DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [4:0] DIRECTION  = DIR_PE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            req_1,
  input  logic [4:0]            req_2,
  input  logic [4:0]            req_3,
  input  logic [4:0]            req_4,
  input  logic [DATA_WIDTH-1:0] data_1,
  input  logic [DATA_WIDTH-1:0] data_2,
  input  logic [DATA_WIDTH-1:0] data_3,
  input  logic [DATA_WIDTH-1:0] data_4,
  output logic                  buf_clear_1,
  output logic                  buf_clear_2,
  output logic                  buf_clear_3,
  output logic                  buf_clear_4,
  output logic                  so,
  input  logic                  ro,
  output logic [DATA_WIDTH-1:0] datao
);

  // An all-zero direction marks an unused output port that never grants.
  localparam logic DirEnabled = (DIRECTION != 5'b00000);

  logic                  valid_q;
  logic                  valid_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;
  logic [NUM_PORTS-1:0]  reqVec;
  logic [NUM_PORTS-1:0]  grant;
  logic [DATA_WIDTH-1:0] dataSel;
  logic                  canLoad;
  logic                  arbEn;

  always_comb begin
    reqVec         = '0;
    reqVec[PORT_1] = |req_1;
    reqVec[PORT_2] = |req_2;
    reqVec[PORT_3] = |req_3;
    reqVec[PORT_4] = |req_4;
    reqVec         = reqVec & {NUM_PORTS{DirEnabled}};
  end

  // The register accepts a new flit when empty or when its flit leaves this edge;
  // gating with rst keeps grants silent while reset is held.
  assign canLoad = !valid_q || ro;
  assign arbEn   = canLoad && rst;

  rr_arbiter_4 u_arbiter (
    .clk     (clk),
    .rst     (rst),
    .req_i   (reqVec),
    .en_i    (arbEn),
    .grant_o (grant)
  );

  always_comb begin
    dataSel = '0;
    if (grant[PORT_1]) dataSel = data_1;
    if (grant[PORT_2]) dataSel = data_2;
    if (grant[PORT_3]) dataSel = data_3;
    if (grant[PORT_4]) dataSel = data_4;
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (|grant) begin
      valid_d = 1'b1;
      data_d  = dataSel;
    end else if (valid_q && ro) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign buf_clear_1 = grant[PORT_1];
  assign buf_clear_2 = grant[PORT_2];
  assign buf_clear_3 = grant[PORT_3];
  assign buf_clear_4 = grant[PORT_4];
  assign so          = valid_q;
  assign datao       = data_q;

endmodule

// File: doc/output_interface.md
OUTPUT_INTERFACE -- requirements
Module: output_interface

Interface
REQ-001 Parameter DATA_WIDTH, default 64: width of flit data on all data ports.
REQ-002 Parameter DIRECTION, default 5'b00001: one-hot output direction served (L 10000, R 01000, U 00100, D 00010, PE 00001).
REQ-003 Port clk  input  1: single clock; all state on rising edge.
REQ-004 Port rst  input  1: asynchronous, active-low reset.
REQ-005 Ports req_1..req_4  input  5 each: request from each of the four other input interfaces; nonzero = requesting this output.
REQ-006 Ports data_1..data_4  input  DATA_WIDTH each: flit offered with the matching req_k.
REQ-007 Ports buf_clear_1..buf_clear_4  output  1 each: grant/clear pulse to the input buffer of requester k.
REQ-008 Port so  output  1: send, output register holds a valid flit.
REQ-009 Port ro  input  1: receive-ready from the downstream input interface.
REQ-010 Port datao  output  DATA_WIDTH: flit in output register.

Function
REQ-011 Single-entry output register (valid bit + DATA_WIDTH data); so equals the valid bit.
REQ-012 Transfer occurs at a rising edge where so=1 and ro=1; valid clears at that edge unless refilled in the same edge.
REQ-013 Register "can load" when valid=0 or (so=1 and ro=1) in the current cycle.
REQ-014 When can-load and at least one req_k nonzero, arbiter grants exactly one k; buf_clear_k high combinationally in that cycle, all other buf_clear low.
REQ-015 At the edge ending a grant cycle, data_k loads into the register and valid sets to 1; latency request-to-so = 1 cycle.
REQ-016 No buf_clear asserted when can-load is 0 or no request is present.
REQ-017 Arbitration round-robin over indices 1..4; 2-bit priority pointer; search starts at pointer, wraps 4->1.
REQ-018 After a grant to k, pointer becomes k+1 (4 wraps to 1); pointer unchanged in cycles with no grant.
REQ-019 Simultaneous drain and refill (so=1, ro=1, request present) yields continuous so=1, one flit per cycle.
REQ-020 ro=0 with valid=1 holds datao and so stable; no grants issued.
REQ-021 Request dropped before grant is ignored; no state kept per requester besides the pointer.
REQ-022 datao undefined-free: holds last loaded value when valid=0.

Reset
REQ-023 rst low forces valid=0, so=0, datao=0, pointer=1 (index 1 highest priority), asynchronously.
REQ-024 While rst low, all buf_clear_k are 0 regardless of requests.
REQ-025 Reset mid-transfer discards the held flit; no buf_clear issued for it again.
REQ-026 First grant possible in the first cycle after rst deasserts.

Structure
REQ-027 Shared package holds direction one-hot encodings (L, R, U, D, PE), DATA_WIDTH default, and port-index constants.
REQ-028 One sub-module rr_arbiter_4: inputs 4-bit request, enable; outputs one-hot 4-bit grant; owns the pointer.
REQ-029 output_interface instantiates rr_arbiter_4 plus the output register and handshake logic only.

Verification
REQ-030 Reset: rst low with req_1=5'b10000 -> so=0, datao=0, buf_clear all 0; release -> buf_clear_1 pulse next cycle, so=1 cycle after.
REQ-031 All four requesting, ro=1 constantly -> grants 1,2,3,4,1 on consecutive cycles, so continuously 1, datao follows data_k in that order.
REQ-032 Backpressure: valid flit 64'hA5, ro=0 for 5 cycles with req_2 active -> datao stays 64'hA5, buf_clear_2 stays 0; ro=1 -> buf_clear_2 pulses same cycle, datao=data_2 next cycle.
REQ-033 Wrap: pointer at 4, only req_1 and req_4 active -> grant 4 then 1, pointer ends at 2.
REQ-034 Reset mid-transfer: rst low while so=1, ro=0 -> so drops immediately; after release no stale flit re-sent.
REQ-035 Idle: no requests for 10 cycles after draining -> so=0, pointer unchanged, buf_clear all 0.
